fifo_write_packer: RTL

FIFO_WRITE_PACKER -- requirements
Module: fifo_write_packer

---
 rtl/fifo_write_packer_if.sv | 20 ++
 rtl/fifo_write_packer.sv | 113 +++++++++++
 2 files changed

// File: rtl/fifo_write_packer_if.sv
// Event-to-FIFO bus: timestamp inputs from the edge timer and the packed write port to the FIFO.
// The master side is the environment (timer + FIFO); the slave side is the packer.
interface fifo_write_packer_if;
  logic [26:0] coarse_in;
  logic [6:0]  fine_in;
  logic        write_request;
  logic        FULL;
  logic [33:0] D;
  logic        WR;

  modport master (
    output coarse_in, fine_in, write_request, FULL,
    input  D, WR
  );

  modport slave (
    input  coarse_in, fine_in, write_request, FULL,
    output D, WR
  );
endinterface

// File: rtl/fifo_write_packer.sv
// Packs {coarse, fine} timestamps into 34-bit FIFO words, waits out back-pressure
// up to HOLD_MAX cycles and keeps saturating loss statistics.
module fifo_write_packer #(
  parameter int FINE_LAT = 2,
  parameter int HOLD_MAX = 255
) (
  input  logic                CLK,
  input  logic                RST,
  fifo_write_packer_if.slave  bus,
  input  logic                clr_stat,
  output logic                busy,
  output logic [15:0]         drop_count,
  output logic                overflow
);

  localparam logic [3:0] LAT_INIT = 4'(FINE_LAT);
  localparam logic [7:0] HOLD_LIM = 8'(HOLD_MAX);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_FINE = 2'd1,
    WRITE     = 2'd2
  } state_t;

  state_t      state_reg;
  logic [26:0] coarse_reg;
  logic [6:0]  fine_reg;
  logic [3:0]  lat_cnt_reg;
  logic [7:0]  hold_cnt_reg;
  logic [33:0] d_reg;
  logic        wr_reg;
  logic        busy_reg;
  logic [15:0] drop_count_reg;
  logic        overflow_reg;

  logic timeout;
  logic drop_evt;

  // A timeout and a rejected request in the same cycle are one lost event.
  assign timeout  = (state_reg == WRITE) && bus.FULL && (hold_cnt_reg == HOLD_LIM);
  assign drop_evt = ((state_reg != IDLE) && bus.write_request) || timeout;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg      <= IDLE;
      coarse_reg     <= '0;
      fine_reg       <= '0;
      lat_cnt_reg    <= '0;
      hold_cnt_reg   <= '0;
      d_reg          <= '0;
      wr_reg         <= 1'b0;
      busy_reg       <= 1'b0;
      drop_count_reg <= '0;
      overflow_reg   <= 1'b0;
    end else begin
      wr_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (bus.write_request) begin
            coarse_reg  <= bus.coarse_in;
            lat_cnt_reg <= LAT_INIT;
            state_reg   <= WAIT_FINE;
            busy_reg    <= 1'b1;
          end
        end
        WAIT_FINE: begin
          lat_cnt_reg <= lat_cnt_reg - 4'd1;
          // Counter reaches 1 on the FINE_LAT-th edge after the request sample.
          if (lat_cnt_reg == 4'd1) begin
            fine_reg     <= bus.fine_in;
            hold_cnt_reg <= '0;
            state_reg    <= WRITE;
          end
        end
        WRITE: begin
          if (!bus.FULL) begin
            d_reg     <= {coarse_reg, fine_reg};
            wr_reg    <= 1'b1;
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if (timeout) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            hold_cnt_reg <= hold_cnt_reg + 8'd1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase

      // Clear wins over history but not over a loss happening in the same cycle.
      if (clr_stat) begin
        drop_count_reg <= drop_evt ? 16'd1 : 16'd0;
        overflow_reg   <= drop_evt;
      end else if (drop_evt) begin
        overflow_reg <= 1'b1;
        if (drop_count_reg != 16'hFFFF) begin
          drop_count_reg <= drop_count_reg + 16'd1;
        end
      end
    end
  end

  assign bus.D      = d_reg;
  assign bus.WR     = wr_reg;
  assign busy       = busy_reg;
  assign drop_count = drop_count_reg;
  assign overflow   = overflow_reg;

endmodule
